// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage core.
// Drives the fd/dx/xm/mw latch enables and flushes and pc_en. The flush
// and stall decisions cover load-use bubbles, dmem-wait freezes, imem-miss
// bubbles and mispredict flushes. It also tracks the halt drain, a dmem-wait
// watchdog and saturating stall/flush performance counters.
module hazard_controller #(
  parameter int CNT_W    = 32,
  parameter int WD_LIMIT = 256
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       fd_rs1,
  input  logic [4:0]       fd_rs2,
  input  logic             fd_use1,
  input  logic             fd_use2,
  input  logic [4:0]       dx_rd,
  input  logic             dx_memRd,
  input  logic             xm_dmemREN,
  input  logic             xm_dmemWEN,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             xm_mispredict,
  input  logic             mw_halt,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             xm_flush,
  output logic             halt,
  output logic             wd_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  localparam int WD_W = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WD_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  state_t          state;
  state_t          stateNext;
  logic [WD_W-1:0] wdCnt;
  logic            dreq;
  logic            loadUse;
  logic            dreqFreeze;
  logic            flushEvt;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign dreq    = (xm_dmemREN | xm_dmemWEN) & ~dhit;
  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign loadUse = dx_memRd & (dx_rd != 5'd0) &
                   ((fd_use1 & (fd_rs1 == dx_rd)) | (fd_use2 & (fd_rs2 == dx_rd)));
  assign halt    = (state == HALT);

  // Prioritised enable/flush decode and next-state selection.
  always_comb begin
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    dx_en      = 1'b1;
    xm_en      = 1'b1;
    mw_en      = 1'b1;
    fd_flush   = 1'b0;
    dx_flush   = 1'b0;
    xm_flush   = 1'b0;
    stateNext  = state;
    dreqFreeze = 1'b0;
    flushEvt   = 1'b0;
    if (state == HALT) begin
      {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b0;
    end else if (mw_halt) begin
      {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b0;
      stateNext = HALT;
    end else if (dreq) begin
      {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b0;
      stateNext  = DWAIT;
      dreqFreeze = 1'b1;
    end else begin
      // dreq has dropped (or never rose): the pipeline resumes this cycle.
      stateNext = RUN;
      if (xm_mispredict) begin
        fd_flush = 1'b1;
        dx_flush = 1'b1;
        xm_flush = 1'b1;
        flushEvt = 1'b1;
      end else if (loadUse) begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        dx_flush = 1'b1;
      end else if (!ihit) begin
        pc_en    = 1'b0;
        fd_flush = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= stateNext;
  end

  // Dmem-wait watchdog: counts consecutive freeze cycles, error is sticky.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wdCnt  <= '0;
      wd_err <= 1'b0;
    end else if (dreqFreeze) begin
      if (wdCnt != WD_MAX) wdCnt <= wdCnt + 1'b1;
      if (wdCnt >= WD_LAST) wd_err <= 1'b1;
    end else begin
      wdCnt <= '0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && state != HALT) stall_cnt <= satInc(stall_cnt);
      if (flushEvt) flush_cnt <= satInc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: directed scenarios plus randomized traffic
// checked against a behavioural model of the sequencing rules.
module tb_hazard_controller;

  localparam int CNT_W    = 3;
  localparam int WD_LIMIT = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic [4:0]       fd_rs1, fd_rs2, dx_rd;
  logic             fd_use1, fd_use2, dx_memRd;
  logic             xm_dmemREN, xm_dmemWEN, dhit, ihit, xm_mispredict, mw_halt;
  logic             pc_en, fd_en, dx_en, xm_en, mw_en;
  logic             fd_flush, dx_flush, xm_flush, halt, wd_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state
  bit mHalt;
  bit mWdErr;
  int mWdRun;
  int mStall;
  int mFlush;

  hazard_controller #(.CNT_W(CNT_W), .WD_LIMIT(WD_LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_use1(fd_use1), .fd_use2(fd_use2),
    .dx_rd(dx_rd), .dx_memRd(dx_memRd),
    .xm_dmemREN(xm_dmemREN), .xm_dmemWEN(xm_dmemWEN),
    .dhit(dhit), .ihit(ihit), .xm_mispredict(xm_mispredict), .mw_halt(mw_halt),
    .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
    .halt(halt), .wd_err(wd_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int satAdd(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic setIdle();
    RST = 0; fd_rs1 = 0; fd_rs2 = 0; fd_use1 = 0; fd_use2 = 0; dx_rd = 0;
    dx_memRd = 0; xm_dmemREN = 0; xm_dmemWEN = 0; dhit = 0; ihit = 1;
    xm_mispredict = 0; mw_halt = 0;
  endtask

  // Called just after inputs are driven on the falling edge: checks the
  // combinational outputs and the registered status, then advances the model
  // to what the coming rising edge should produce.
  task automatic runCycle();
    logic [7:0] exp;
    bit dreqM, luM, stallNow;
    #1;
    dreqM = (xm_dmemREN || xm_dmemWEN) && !dhit;
    luM   = dx_memRd && dx_rd != 0 &&
            ((fd_use1 && fd_rs1 == dx_rd) || (fd_use2 && fd_rs2 == dx_rd));
    // order: pc, fd, dx, xm, mw, fd_flush, dx_flush, xm_flush
    if (mHalt || mw_halt || dreqM) exp = 8'b00000_000;
    else if (xm_mispredict)        exp = 8'b11111_111;
    else if (luM)                  exp = 8'b00111_010;
    else if (!ihit)                exp = 8'b01111_100;
    else                           exp = 8'b11111_000;
    checkVal("outs", {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush}, {24'd0, exp});
    checkVal("halt", {31'd0, halt}, {31'd0, mHalt});
    checkVal("wd_err", {31'd0, wd_err}, {31'd0, mWdErr});
    checkVal("stall_cnt", {29'd0, stall_cnt}, mStall);
    checkVal("flush_cnt", {29'd0, flush_cnt}, mFlush);

    stallNow = !exp[7] && !mHalt;
    if (RST) begin
      mHalt = 0; mWdErr = 0; mWdRun = 0; mStall = 0; mFlush = 0;
    end else begin
      if (stallNow) mStall = satAdd(mStall);
      if (!mHalt && !mw_halt && dreqM) begin
        mWdRun++;
        if (mWdRun >= WD_LIMIT) mWdErr = 1;
      end else begin
        mWdRun = 0;
      end
      if (!mHalt && mw_halt) mHalt = 1;
      if (!mHalt && !dreqM && xm_mispredict) mFlush = satAdd(mFlush);
    end
  endtask

  task automatic doReset();
    @(negedge CLK); setIdle(); RST = 1; runCycle();
    @(negedge CLK); setIdle();
  endtask

  initial begin
    setIdle();
    RST = 1;
    repeat (2) @(posedge CLK);
    mHalt = 0; mWdErr = 0; mWdRun = 0; mStall = 0; mFlush = 0;
    @(negedge CLK); setIdle();
    runCycle();
    checkVal("reset_pc_en", {31'd0, pc_en}, 32'd1);
    checkVal("reset_stall", {29'd0, stall_cnt}, 32'd0);

    // Load-use on x5: exactly one bubble
    @(negedge CLK); setIdle();
    dx_memRd = 1; dx_rd = 5; fd_rs1 = 5; fd_use1 = 1;
    runCycle();
    checkVal("lu_pc_en", {31'd0, pc_en}, 32'd0);
    checkVal("lu_fd_en", {31'd0, fd_en}, 32'd0);
    checkVal("lu_dx_flush", {31'd0, dx_flush}, 32'd1);
    // x0 destination: no stall
    @(negedge CLK); setIdle();
    dx_memRd = 1; dx_rd = 0; fd_rs1 = 0; fd_use1 = 1;
    runCycle();
    checkVal("x0_pc_en", {31'd0, pc_en}, 32'd1);

    // dmem wait of 3 cycles
    doReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); setIdle(); xm_dmemREN = 1; dhit = 0; runCycle();
      checkVal("dw_en", {27'd0, pc_en, fd_en, dx_en, xm_en, mw_en}, 32'd0);
    end
    @(negedge CLK); setIdle(); xm_dmemREN = 1; dhit = 1; runCycle();
    checkVal("dw_stall3", {29'd0, stall_cnt}, 32'd3);
    checkVal("dw_release", {31'd0, pc_en}, 32'd1);
    checkVal("dw_no_wd", {31'd0, wd_err}, 32'd0);

    // Mispredict with load-use and imem miss in the same cycle
    doReset();
    @(negedge CLK); setIdle();
    xm_mispredict = 1; ihit = 0; dx_memRd = 1; dx_rd = 7; fd_rs2 = 7; fd_use2 = 1;
    runCycle();
    checkVal("mp_flushes", {29'd0, fd_flush, dx_flush, xm_flush}, 32'd7);
    checkVal("mp_pc_en", {31'd0, pc_en}, 32'd1);
    @(negedge CLK); setIdle(); runCycle();
    checkVal("mp_flush_cnt", {29'd0, flush_cnt}, 32'd1);

    // Watchdog: 10 cycles of dmem wait
    doReset();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); setIdle(); xm_dmemWEN = 1; dhit = 0; runCycle();
      checkVal("wd_seq", {31'd0, wd_err}, (i >= WD_LIMIT) ? 32'd1 : 32'd0);
    end
    @(negedge CLK); setIdle(); runCycle();
    checkVal("wd_sticky", {31'd0, wd_err}, 32'd1);

    // Halt pulse, then reset clears it
    doReset();
    @(negedge CLK); setIdle(); mw_halt = 1; runCycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); setIdle(); runCycle();
      checkVal("halt_on", {31'd0, halt}, 32'd1);
      checkVal("halt_en", {27'd0, pc_en, fd_en, dx_en, xm_en, mw_en}, 32'd0);
    end
    doReset();
    runCycle();
    checkVal("halt_cleared", {31'd0, halt}, 32'd0);
    checkVal("halt_cnt0", {29'd0, stall_cnt}, 32'd0);

    // Stall counter saturation
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK); setIdle(); ihit = 0; runCycle();
    end
    @(negedge CLK); setIdle(); runCycle();
    checkVal("stall_sat", {29'd0, stall_cnt}, CNT_MAX);

    // Randomized traffic
    doReset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      RST           = ($urandom_range(0, 99) == 0);
      fd_rs1        = 5'($urandom_range(0, 7));
      fd_rs2        = 5'($urandom_range(0, 7));
      dx_rd         = 5'($urandom_range(0, 7));
      fd_use1       = $urandom_range(0, 1) == 1;
      fd_use2       = $urandom_range(0, 1) == 1;
      dx_memRd      = $urandom_range(0, 2) == 0;
      xm_dmemREN    = $urandom_range(0, 3) == 0;
      xm_dmemWEN    = $urandom_range(0, 7) == 0;
      dhit          = $urandom_range(0, 9) < 4;
      ihit          = $urandom_range(0, 3) != 0;
      xm_mispredict = $urandom_range(0, 7) == 0;
      mw_halt       = $urandom_range(0, 59) == 0;
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
